life_reg_sequencer: RTL and testbench

LIFE_REG_SEQUENCER -- requirements
Module: life_reg_sequencer

---
 rtl/life_reg_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_life_reg_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_reg_sequencer.sv
// Two-client register sequencer: round-robin arbitration between c0/c1 and a
// single AXI4-Lite master port, with a sticky per-phase watchdog flag.
module life_reg_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [1:0]  c0_idx,
  input  logic [31:0] c0_wdata,
  output logic        c0_ack,
  output logic [31:0] c0_rdata,
  output logic [1:0]  c0_resp,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [1:0]  c1_idx,
  input  logic [31:0] c1_wdata,
  output logic        c1_ack,
  output logic [31:0] c1_rdata,
  output logic [1:0]  c1_resp,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, ACK} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        c0_ack_q, c0_ack_d;
  logic        c1_ack_q, c1_ack_d;
  logic [31:0] c0_rdata_q, c0_rdata_d;
  logic [31:0] c1_rdata_q, c1_rdata_d;
  logic [1:0]  c0_resp_q, c0_resp_d;
  logic [1:0]  c1_resp_q, c1_resp_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        pick;
  logic        busy;
  logic [31:0] addr;

  // idx_q is frozen for the whole transfer, so the address is stable under VALID.
  assign addr = BASE_ADDR + {28'd0, idx_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    c0_ack_d     = 1'b0;
    c1_ack_d     = 1'b0;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    c0_resp_d    = c0_resp_q;
    c1_resp_d    = c1_resp_q;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          // On a tie the client that did not win last time gets the grant.
          pick         = (c0_req && c1_req) ? ~last_grant_q : c1_req;
          grant_d      = pick;
          last_grant_d = pick;
          we_d         = pick ? c1_we    : c0_we;
          idx_d        = pick ? c1_idx   : c0_idx;
          wdata_d      = pick ? c1_wdata : c0_wdata;
          if (pick ? c1_we : c0_we) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          state_d  = ACK;
          if (grant_q) begin
            c1_resp_d = M_AXI_BRESP;
            c1_ack_d  = 1'b1;
          end else begin
            c0_resp_d = M_AXI_BRESP;
            c0_ack_d  = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          state_d  = ACK;
          if (grant_q) begin
            c1_rdata_d = M_AXI_RDATA;
            c1_resp_d  = M_AXI_RRESP;
            c1_ack_d   = 1'b1;
          end else begin
            c0_rdata_d = M_AXI_RDATA;
            c0_resp_d  = M_AXI_RRESP;
            c0_ack_d   = 1'b1;
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Watchdog: counts stalled cycles within one AXI phase; never aborts the transfer.
  always_comb begin
    busy = (state_q == WR) || (state_q == WR_RESP) ||
           (state_q == RD_ADDR) || (state_q == RD_DATA);
    wd_cnt_d = 32'd0;
    if (busy && (state_d == state_q)) begin
      wd_cnt_d = (wd_cnt_q == 32'hFFFF_FFFF) ? wd_cnt_q : wd_cnt_q + 32'd1;
    end
    timeout_d = timeout_q | (wd_cnt_q >= 32'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= 2'd0;
      wdata_q      <= 32'd0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      c0_ack_q     <= 1'b0;
      c1_ack_q     <= 1'b0;
      c0_rdata_q   <= 32'd0;
      c1_rdata_q   <= 32'd0;
      c0_resp_q    <= 2'd0;
      c1_resp_q    <= 2'd0;
      wd_cnt_q     <= 32'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      c0_ack_q     <= c0_ack_d;
      c1_ack_q     <= c1_ack_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      c0_resp_q    <= c0_resp_d;
      c1_resp_q    <= c1_resp_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign c0_ack        = c0_ack_q;
  assign c1_ack        = c1_ack_q;
  assign c0_rdata      = c0_rdata_q;
  assign c1_rdata      = c1_rdata_q;
  assign c0_resp       = c0_resp_q;
  assign c1_resp       = c1_resp_q;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_life_reg_sequencer.sv
// Directed bench for life_reg_sequencer: behavioural AXI-Lite slave with
// programmable stalls, a vector table and hand-written corner-case sequences.
module tb_life_reg_sequencer;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          TMO  = 16;

  logic        ACLK, ARESET;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [1:0]  c0_idx, c1_idx;
  logic [31:0] c0_wdata, c1_wdata;
  logic        c0_ack, c1_ack;
  logic [31:0] c0_rdata, c1_rdata;
  logic [1:0]  c0_resp, c1_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic        timeout;

  life_reg_sequencer #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .c0_req(c0_req), .c0_we(c0_we), .c0_idx(c0_idx), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_resp(c0_resp),
    .c1_req(c1_req), .c1_we(c1_we), .c1_idx(c1_idx), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_resp(c1_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .timeout(timeout)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- behavioural slave ----------------
  int          aw_delay, w_delay, b_delay, r_delay;
  logic [1:0]  bresp_cfg, rresp_cfg;
  int          aw_cnt, w_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_a;
  logic [31:0] mem [4];
  logic        awhs, whs;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_delay);
  assign M_AXI_BVALID  = b_pend && (b_cnt >= b_delay);
  assign M_AXI_BRESP   = bresp_cfg;
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign M_AXI_RVALID  = r_pend && (r_cnt >= r_delay);
  assign M_AXI_RDATA   = mem[r_a[3:2]];
  assign M_AXI_RRESP   = rresp_cfg;
  assign awhs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign whs  = M_AXI_WVALID && M_AXI_WREADY;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= 32'd0; w_d <= 32'd0; r_a <= 32'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'd0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      if (awhs) begin aw_got <= 1'b1; aw_a <= M_AXI_AWADDR; end
      if (whs)  begin w_got <= 1'b1;  w_d  <= M_AXI_WDATA;  end
      if ((aw_got || awhs) && (w_got || whs) && !b_pend) begin
        mem[awhs ? M_AXI_AWADDR[3:2] : aw_a[3:2]] <= whs ? M_AXI_WDATA : w_d;
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_pend) begin
        if (M_AXI_BVALID && M_AXI_BREADY) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        r_pend <= 1'b1; r_cnt <= 0; r_a <= M_AXI_ARADDR;
      end else if (r_pend) begin
        if (M_AXI_RVALID && M_AXI_RREADY) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- bus monitor (sampled mid-cycle) ----------------
  int          ack0_cnt = 0, ack1_cnt = 0, awv_cyc = 0, wv_cyc = 0, b_hs = 0;
  logic [31:0] last_aw = 32'd0, last_ar = 32'd0;

  always @(negedge ACLK) begin
    if (c0_ack) ack0_cnt <= ack0_cnt + 1;
    if (c1_ack) ack1_cnt <= ack1_cnt + 1;
    if (M_AXI_AWVALID) awv_cyc <= awv_cyc + 1;
    if (M_AXI_WVALID)  wv_cyc  <= wv_cyc + 1;
    if (M_AXI_BVALID && M_AXI_BREADY) b_hs <= b_hs + 1;
    if (awhs) last_aw <= M_AXI_AWADDR;
    if (M_AXI_ARVALID && M_AXI_ARREADY) last_ar <= M_AXI_ARADDR;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int client, input bit we, input logic [1:0] idx,
                         input logic [31:0] wdata, output bit got, output int lat,
                         output logic [31:0] rd, output logic [1:0] rs);
    @(negedge ACLK);
    if (client == 0) begin
      c0_req = 1'b1; c0_we = we; c0_idx = idx; c0_wdata = wdata;
    end else begin
      c1_req = 1'b1; c1_we = we; c1_idx = idx; c1_wdata = wdata;
    end
    got = 1'b0; lat = 0; rd = 32'd0; rs = 2'd0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge ACLK);
      if (client == 0 && c0_ack) begin got = 1'b1; lat = k; rd = c0_rdata; rs = c0_resp; end
      if (client == 1 && c1_ack) begin got = 1'b1; lat = k; rd = c1_rdata; rs = c1_resp; end
    end
    c0_req = 1'b0; c1_req = 1'b0;
  endtask

  typedef struct {
    int          client;
    bit          we;
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        tbl [10];
  bit          got;
  int          lat, a0, a1, s_aw, s_w, s_b;
  logic [31:0] rd;
  logic [1:0]  rs;
  int          order [$];

  initial begin
    tbl[0] = '{0, 1'b1, 2'd0, 32'h0101_FFFF, 32'h4000_1000, 32'h0, 2'b00};
    tbl[1] = '{0, 1'b0, 2'd0, 32'h0,         32'h4000_1000, 32'h0101_FFFF, 2'b00};
    tbl[2] = '{0, 1'b1, 2'd1, 32'hABCD_0001, 32'h4000_1004, 32'h0, 2'b00};
    tbl[3] = '{0, 1'b0, 2'd1, 32'h0,         32'h4000_1004, 32'hABCD_0001, 2'b00};
    tbl[4] = '{0, 1'b1, 2'd2, 32'hDEAD_0011, 32'h4000_1008, 32'h0, 2'b00};
    tbl[5] = '{0, 1'b0, 2'd2, 32'h0,         32'h4000_1008, 32'hDEAD_0011, 2'b00};
    tbl[6] = '{0, 1'b1, 2'd3, 32'hBEEF_0011, 32'h4000_100C, 32'h0, 2'b00};
    tbl[7] = '{0, 1'b0, 2'd3, 32'h0,         32'h4000_100C, 32'hBEEF_0011, 2'b00};
    tbl[8] = '{1, 1'b1, 2'd1, 32'h1234_5678, 32'h4000_1004, 32'h0, 2'b00};
    tbl[9] = '{1, 1'b0, 2'd1, 32'h0,         32'h4000_1004, 32'h1234_5678, 2'b00};

    ARESET = 1'b1;
    c0_req = 1'b0; c0_we = 1'b0; c0_idx = 2'd0; c0_wdata = 32'd0;
    c1_req = 1'b0; c1_we = 1'b0; c1_idx = 2'd0; c1_wdata = 32'd0;
    aw_delay = 0; w_delay = 0; b_delay = 0; r_delay = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    repeat (3) @(negedge ACLK);

    chk("rst_c0_ack", {31'd0, c0_ack}, 32'd0);
    chk("rst_c1_ack", {31'd0, c1_ack}, 32'd0);
    chk("rst_valids", {28'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, 1'b0}, 32'd0);
    chk("rst_readys", {30'd0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_rdata", c0_rdata | c1_rdata, 32'd0);
    chk("rst_resp", {28'd0, c0_resp, c1_resp}, 32'd0);
    ARESET = 1'b0;

    // Table: writes then read-backs, address and response per transfer.
    for (int i = 0; i < 10; i++) begin
      a0 = ack0_cnt; a1 = ack1_cnt;
      run_txn(tbl[i].client, tbl[i].we, tbl[i].idx, tbl[i].wdata, got, lat, rd, rs);
      #1;
      chk($sformatf("v%0d_ack", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_addr", i), tbl[i].we ? last_aw : last_ar, tbl[i].exp_addr);
      chk($sformatf("v%0d_resp", i), {30'd0, rs}, {30'd0, tbl[i].exp_resp});
      if (!tbl[i].we) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("v%0d_ackcnt", i), ack0_cnt - a0 + 2 * (ack1_cnt - a1),
          (tbl[i].client == 0) ? 32'd1 : 32'd2);
      if (i == 0) chk("v0_write_latency", lat, 32'd3);
      $display("txn %0d: c%0d we=%0b idx=%0d lat=%0d rdata=%h resp=%0d",
               i, tbl[i].client, tbl[i].we, tbl[i].idx, lat, rd, rs);
    end
    chk("prot_strb", {25'd0, M_AXI_AWPROT, M_AXI_WSTRB}, 32'h0000_000F);

    // Three simultaneous request rounds; record grant order from the acks.
    for (int r = 0; r < 3; r++) begin
      a0 = 0; a1 = 0;
      @(negedge ACLK);
      c0_req = 1'b1; c0_we = 1'b0; c0_idx = 2'd0;
      c1_req = 1'b1; c1_we = 1'b0; c1_idx = 2'd0;
      for (int k = 0; k < 100 && (c0_req || c1_req); k++) begin
        @(negedge ACLK);
        if (c0_ack) begin a0++; order.push_back(0); c0_req = 1'b0; end
        if (c1_ack) begin a1++; order.push_back(1); c1_req = 1'b0; end
      end
      c0_req = 1'b0; c1_req = 1'b0;
      chk($sformatf("rr%0d_acks", r), {a0[15:0], a1[15:0]}, 32'h0001_0001);
      $display("txn rr round %0d: c0 acks=%0d c1 acks=%0d", r, a0, a1);
    end
    chk("rr_count", order.size(), 32'd6);
    if (order.size() >= 3) begin
      chk("rr_grant0", order[0], 32'd0);
      chk("rr_grant1", order[1], 32'd1);
      chk("rr_grant2", order[2], 32'd0);
    end

    // AWREADY stalled three cycles while WREADY is immediate.
    aw_delay = 3;
    #1; s_aw = awv_cyc; s_w = wv_cyc; s_b = b_hs;
    run_txn(0, 1'b1, 2'd2, 32'h7777_0000, got, lat, rd, rs);
    #1;
    aw_delay = 0;
    chk("awdly_ack", {31'd0, got}, 32'd1);
    chk("awdly_awvalid_cycles", awv_cyc - s_aw, 32'd4);
    chk("awdly_wvalid_cycles", wv_cyc - s_w, 32'd1);
    chk("awdly_b_handshakes", b_hs - s_b, 32'd1);
    $display("txn awdly: lat=%0d resp=%0d", lat, rs);

    // SLVERR on a read for c1 is forwarded; the bus is idle afterwards.
    rresp_cfg = 2'b10;
    run_txn(1, 1'b0, 2'd0, 32'h0, got, lat, rd, rs);
    rresp_cfg = 2'b00;
    chk("slverr_ack", {31'd0, got}, 32'd1);
    chk("slverr_resp", {30'd0, rs}, 32'd2);
    chk("slverr_rdata", rd, 32'h0101_FFFF);
    @(negedge ACLK);
    chk("slverr_idle_bus", {29'd0, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID}, 32'd0);
    run_txn(1, 1'b0, 2'd0, 32'h0, got, lat, rd, rs);
    chk("slverr_next_resp", {30'd0, rs, 1'b0, got}, 32'h0000_0001);
    $display("txn slverr: follow-up lat=%0d resp=%0d", lat, rs);

    // BVALID withheld past the watchdog limit; transfer still completes.
    chk("wd_clear_before", {31'd0, timeout}, 32'd0);
    b_delay = TMO + 5; bresp_cfg = 2'b10;
    run_txn(0, 1'b1, 2'd3, 32'h5A5A_0000, got, lat, rd, rs);
    b_delay = 0; bresp_cfg = 2'b00;
    chk("wd_ack", {31'd0, got}, 32'd1);
    chk("wd_resp", {30'd0, rs}, 32'd2);
    chk("wd_timeout_set", {31'd0, timeout}, 32'd1);
    run_txn(0, 1'b0, 2'd3, 32'h0, got, lat, rd, rs);
    chk("wd_readback", rd, 32'h5A5A_0000);
    chk("wd_timeout_sticky", {31'd0, timeout}, 32'd1);
    $display("txn watchdog: readback=%h timeout=%0b", rd, timeout);

    // Reset while waiting in RD_DATA drops the read with no ack.
    r_delay = 10;
    #1; a0 = ack0_cnt;
    @(negedge ACLK);
    c0_req = 1'b1; c0_we = 1'b0; c0_idx = 2'd1;
    repeat (2) @(negedge ACLK);
    chk("mid_rst_rready_before", {31'd0, M_AXI_RREADY}, 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_rready", {31'd0, M_AXI_RREADY}, 32'd0);
    chk("mid_rst_arvalid", {31'd0, M_AXI_ARVALID}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    ARESET = 1'b0; c0_req = 1'b0; r_delay = 0;
    repeat (5) @(negedge ACLK);
    #1;
    chk("mid_rst_no_ack", ack0_cnt - a0, 32'd0);
    run_txn(0, 1'b1, 2'd1, 32'hC0FF_EE01, got, lat, rd, rs);
    chk("post_rst_wr_ack", {31'd0, got}, 32'd1);
    run_txn(0, 1'b0, 2'd1, 32'h0, got, lat, rd, rs);
    chk("post_rst_rd_ack", {31'd0, got}, 32'd1);
    chk("post_rst_rdata", rd, 32'hC0FF_EE01);
    $display("txn post-reset: rdata=%h resp=%0d", rd, rs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
